// File: rtl/deadlock_report_scheduler.sv
// Confirms persistent per-monitor block flags and reports them one at a time, round-robin.
// Optional DEADLOCK_TIMESTAMP_EN adds a free-running cycle counter latched into rpt_ts at grant.
module deadlock_report_scheduler #(
    parameter int N_MON  = 4,
    parameter int THRESH = 1024,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = 2,
    parameter int TS_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [N_MON-1:0] mon_block,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [IDX_W-1:0] rpt_idx,
    output logic [CNT_W-1:0] rpt_cycles,
`ifdef DEADLOCK_TIMESTAMP_EN
    output logic [TS_W-1:0]  rpt_ts,
`endif
    output logic             any_deadlock
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THR_M1  = CNT_W'(THRESH - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                        state_q, state_d;
    logic [N_MON-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_MON-1:0]              pending_q, pending_d;
    logic [N_MON-1:0]              reported_q, reported_d;
    logic [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic                          rpt_valid_q, rpt_valid_d;
    logic [IDX_W-1:0]              rpt_idx_q, rpt_idx_d;
    logic [CNT_W-1:0]              rpt_cycles_q, rpt_cycles_d;
    logic                          any_q, any_d;
    logic                          gnt_found;
    logic [IDX_W-1:0]              gnt_idx;
    logic                          accept;
`ifdef DEADLOCK_TIMESTAMP_EN
    logic [TS_W-1:0]               ts_q, ts_d;
    logic [TS_W-1:0]               rpt_ts_q, rpt_ts_d;
`endif

    // First pending bit at or after rr_ptr, wrapping.
    always_comb begin
        int j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N_MON; k++) begin
            j = (int'(rr_ptr_q) + k) % N_MON;
            if (!gnt_found && pending_q[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(j);
            end
        end
    end

    assign accept = (state_q == SEND) && rpt_valid_q && rpt_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        reported_d   = reported_q;
        rr_ptr_d     = rr_ptr_q;
        rpt_valid_d  = rpt_valid_q;
        rpt_idx_d    = rpt_idx_q;
        rpt_cycles_d = rpt_cycles_q;
        any_d        = any_q;
`ifdef DEADLOCK_TIMESTAMP_EN
        ts_d         = ts_q + TS_W'(1);
        rpt_ts_d     = rpt_ts_q;
`endif
        for (int i = 0; i < N_MON; i++) begin
            if (!enable || !mon_block[i])
                cnt_d[i] = '0;
            else if (cnt_q[i] != CNT_MAX)
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            if (cnt_q[i] == THR_M1 && mon_block[i] && enable && !reported_q[i])
                pending_d[i] = 1'b1;
            if (!mon_block[i])
                reported_d[i] = 1'b0;
        end
        case (state_q)
            IDLE: if (gnt_found) begin
                rpt_idx_d    = gnt_idx;
                rpt_cycles_d = cnt_q[gnt_idx];
                rpt_valid_d  = 1'b1;
                state_d      = SEND;
`ifdef DEADLOCK_TIMESTAMP_EN
                rpt_ts_d     = ts_q + TS_W'(1);
`endif
            end
            SEND: if (accept) begin
                // Accept wins over a same-edge drop of the flag; re-arm happens next edge.
                pending_d[rpt_idx_q]  = 1'b0;
                reported_d[rpt_idx_q] = 1'b1;
                any_d                 = 1'b1;
                rr_ptr_d    = (int'(rpt_idx_q) == N_MON - 1) ? '0 : rpt_idx_q + IDX_W'(1);
                rpt_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            cnt_d       = '0;
            pending_d   = '0;
            reported_d  = '0;
            any_d       = 1'b0;
            rr_ptr_d    = '0;
            rpt_valid_d = 1'b0;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pending_q    <= '0;
            reported_q   <= '0;
            rr_ptr_q     <= '0;
            rpt_valid_q  <= 1'b0;
            rpt_idx_q    <= '0;
            rpt_cycles_q <= '0;
            any_q        <= 1'b0;
`ifdef DEADLOCK_TIMESTAMP_EN
            ts_q         <= '0;
            rpt_ts_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            reported_q   <= reported_d;
            rr_ptr_q     <= rr_ptr_d;
            rpt_valid_q  <= rpt_valid_d;
            rpt_idx_q    <= rpt_idx_d;
            rpt_cycles_q <= rpt_cycles_d;
            any_q        <= any_d;
`ifdef DEADLOCK_TIMESTAMP_EN
            ts_q         <= ts_d;
            rpt_ts_q     <= rpt_ts_d;
`endif
        end
    end

    assign rpt_valid    = rpt_valid_q;
    assign rpt_idx      = rpt_idx_q;
    assign rpt_cycles   = rpt_cycles_q;
    assign any_deadlock = any_q;
`ifdef DEADLOCK_TIMESTAMP_EN
    assign rpt_ts       = rpt_ts_q;
`endif
endmodule
